out_port: RTL

- Output-port stage of the nic8 CPU; sits between the core's execute stage and the simulation monitor/external sink.
- Captures each OUT-instruction write into the architectural `qreg`, which drives the monitor's `qreg` input.
- Also buffers written values in a small synchronous FIFO. This lets a slower downstream consumer (UART/LED driver) drain them by ready/valid without stalling the CPU.

---
 rtl/nic8_pkg.sv | 8 +
 rtl/out_fifo.sv | 80 ++++++++
 rtl/out_port.sv | 76 +++++++
 3 files changed

// File: rtl/nic8_pkg.sv
// Shared nic8 definitions: machine word width and word type.
package nic8_pkg;

    localparam int unsigned WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

endpackage : nic8_pkg

// File: rtl/out_fifo.sv
// Generic synchronous FIFO with registered occupancy, full and empty flags.
// Pop while empty is ignored; push while full is accepted only with a pop.
module out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Qualify requests, advance pointers (power-of-two wrap) and track occupancy.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    // State registers; storage is cleared on reset so the head reads 0 when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule : out_fifo

// File: rtl/out_port.sv
// nic8 output port: architectural Q register plus a ready/valid FIFO toward
// the external sink, with a sticky overflow flag for dropped writes.
// Optional OUT_PORT_DEDUP_EN: writes equal to the current qreg are not queued.
module out_port
    import nic8_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           qreg,
    output logic                       m_valid,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       full
);

    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic             ovf_q, ovf_d;
    logic             dup_c;
    logic             push_c;
    logic             pop_c;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef OUT_PORT_DEDUP_EN
    assign dup_c = wr_en && (wr_data == qreg_q);
`else
    assign dup_c = 1'b0;
`endif

    // Push gating, Q register update and overflow detection.
    always_comb begin
        pop_c  = !fifo_empty && m_ready;
        push_c = wr_en && !dup_c && (!fifo_full || pop_c);
        qreg_d = wr_en ? wr_data : qreg_q;
        ovf_d  = ovf_q || (wr_en && !dup_c && fifo_full && !pop_c);
    end

    // Q register and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            qreg_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            qreg_q <= qreg_d;
            ovf_q  <= ovf_d;
        end
    end

    out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (wr_data),
        .rdata (m_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign qreg     = qreg_q;
    assign overflow = ovf_q;
    assign full     = fifo_full;
    assign m_valid  = !fifo_empty;

endmodule : out_port
